decodificador_quadratura: RTL and testbench

Quadrature encoder decoder that drives the increment/decrement interface of the team's up/down counter. It synchronizes and debounces the raw encoder phases A/B and decodes Gray-code transitions. Each valid step produces a single-cycle acrescer or decrecer pulse; illegal transitions raise an error flag. It sits between board I/O pins and the counter's acrescer/decrecer inputs.

---
 rtl/decodificador_quadratura.sv | 125 ++++++++++++
 tb/tb_decodificador_quadratura.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decodificador_quadratura.sv
// Quadrature encoder decoder: synchronizes and debounces phases A/B, then turns
// Gray-code steps into single-cycle acrescer/decrecer pulses and flags illegal jumps.
module decodificador_quadratura #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_a,
  input  logic enc_b,
  input  logic limpar_erro,
  output logic acrescer,
  output logic decrecer,
  output logic erro,
  output logic erro_sticky
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int                INIT_W    = CNT_W + 1;
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 1);

  // Phase vectors are indexed [1] = A, [0] = B so {a,b} reads naturally.
  logic [1:0]        r_s1;
  logic [1:0]        r_s2;
  logic [1:0]        r_filt;
  logic [1:0]        r_prev;
  logic [CNT_W-1:0]  r_cnt [2];
  logic [INIT_W-1:0] r_init_cnt;
  state_t            r_state;

  logic [1:0]        w_filt_next;
  logic [CNT_W-1:0]  w_cnt_next [2];
  state_t            w_state_next;
  logic              w_acrescer;
  logic              w_decrecer;
  logic              w_erro;

  // Debounce: a phase must disagree with its filtered value for DEBOUNCE_CYCLES
  // consecutive edges before it is accepted; INIT copies the synchronized level.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    w_filt_next = r_filt;
    for (int i = 0; i < 2; i++) begin
      w_cnt_next[i] = '0;
      if (r_state == ST_INIT) begin
        w_filt_next[i] = r_s2[i];
      end else if (r_s2[i] != r_filt[i]) begin
        if (r_cnt[i] == DB_LAST) begin
          w_filt_next[i] = r_s2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_acrescer   = 1'b0;
    w_decrecer   = 1'b0;
    w_erro       = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == INIT_LAST) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        case ({r_prev, r_filt})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_acrescer = 1'b1;
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_decrecer = 1'b1;
          4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_erro     = 1'b1;
          default: ;
        endcase
      end
      default: w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_filt      <= '0;
      r_prev      <= '0;
      // NOTE: the two-entry counter array is reset like any other register;
      // it is state that the debounce compare reads on the first edge.
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
      r_init_cnt  <= '0;
      r_state     <= ST_INIT;
      acrescer    <= 1'b0;
      decrecer    <= 1'b0;
      erro        <= 1'b0;
      erro_sticky <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, which is what makes the 2-FF chain a chain.
      r_s1   <= {enc_a, enc_b};
      r_s2   <= r_s1;
      r_filt <= w_filt_next;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      // Keeping prev aligned with the filtered pair during INIT means the
      // power-up level never looks like a step once RUN starts.
      r_prev     <= (r_state == ST_INIT) ? r_s2 : r_filt;
      r_init_cnt <= (r_state == ST_INIT) ? r_init_cnt + 1'b1 : r_init_cnt;
      r_state    <= w_state_next;
      acrescer   <= w_acrescer;
      decrecer   <= w_decrecer;
      erro       <= w_erro;
      if (w_erro) begin
        erro_sticky <= 1'b1;
      end else if (limpar_erro) begin
        erro_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decodificador_quadratura.sv
// Bench for decodificador_quadratura: scenario tasks compare the observed pulse
// stream against a Gray-position model of the encoder.
module tb_decodificador_quadratura;

  localparam int D    = 4;
  localparam int LAT  = D + 3;
  localparam int EV_A = 1;
  localparam int EV_D = 2;
  localparam int EV_E = 4;

  logic clk         = 1'b0;
  logic rst_n       = 1'b0;
  logic enc_a       = 1'b0;
  logic enc_b       = 1'b0;
  logic limpar_erro = 1'b0;
  logic acrescer;
  logic decrecer;
  logic erro;
  logic erro_sticky;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;
  int   obs_q[$];
  int   exp_q[$];
  logic [1:0] model_pair;
  bit   model_sticky;

  decodificador_quadratura #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .limpar_erro(limpar_erro),
    .acrescer   (acrescer),
    .decrecer   (decrecer),
    .erro       (erro),
    .erro_sticky(erro_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every high output cycle becomes one event: cycle stamp * 8 + {erro,decrecer,acrescer}.
  always @(negedge clk) begin
    if (mon_en && (acrescer || decrecer || erro)) begin
      obs_q.push_back(cyc * 8 + int'({erro, decrecer, acrescer}));
    end
  end

  // Position of a pair along the forward Gray cycle 00 -> 01 -> 11 -> 10.
  function automatic int gray_pos(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic drive_pair(input logic [1:0] p, input int hold, input bit modeled);
    int step;
    {enc_a, enc_b} = p;
    if (modeled) begin
      step = (gray_pos(p) - gray_pos(model_pair) + 4) % 4;
      if (step == 1) begin
        exp_q.push_back((cyc + LAT) * 8 + EV_A);
      end else if (step == 3) begin
        exp_q.push_back((cyc + LAT) * 8 + EV_D);
      end else if (step == 2) begin
        exp_q.push_back((cyc + LAT) * 8 + EV_E);
        model_sticky = 1'b1;
      end
    end
    model_pair = p;
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] p);
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    {enc_a, enc_b} = p;
    limpar_erro = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (D + 8) @(negedge clk);
    model_pair   = p;
    model_sticky = 1'b0;
    obs_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {enc_a, enc_b} = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if ({acrescer, decrecer, erro, erro_sticky} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 0000", {acrescer, decrecer, erro, erro_sticky});
    end
    obs_q.delete();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_powerup_pulses: got %0d events, expected 0", obs_q.size());
    end
    checks++;
    if (erro_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_sticky: got %b, expected 0", erro_sticky);
    end
  endtask

  task automatic test_forward();
    int contador;
    do_reset(2'b00);
    drive_pair(2'b01, 10, 1);
    drive_pair(2'b11, 10, 1);
    drive_pair(2'b10, 10, 1);
    drive_pair(2'b00, 10, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL fwd_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL fwd_event[%0d]: got cycle %0d kind %0d, expected cycle %0d kind %0d",
                   i, obs_q[i] / 8, obs_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
        end
      end
    end
    contador = 106;
    foreach (obs_q[i]) begin
      if (obs_q[i] % 8 == EV_A) contador++;
      if (obs_q[i] % 8 == EV_D) contador--;
    end
    checks++;
    if (contador != 110) begin
      errors++;
      $display("FAIL fwd_contador: got %0d, expected 110", contador);
    end
  endtask

  task automatic test_reverse();
    int contador;
    do_reset(2'b00);
    drive_pair(2'b10, 10, 1);
    drive_pair(2'b11, 10, 1);
    drive_pair(2'b01, 10, 1);
    drive_pair(2'b00, 10, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rev_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rev_event[%0d]: got cycle %0d kind %0d, expected cycle %0d kind %0d",
                   i, obs_q[i] / 8, obs_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
        end
      end
    end
    contador = 106;
    foreach (obs_q[i]) begin
      if (obs_q[i] % 8 == EV_A) contador++;
      if (obs_q[i] % 8 == EV_D) contador--;
    end
    checks++;
    if (contador != 102) begin
      errors++;
      $display("FAIL rev_contador: got %0d, expected 102", contador);
    end
  endtask

  task automatic test_glitch();
    int filt_a_high;
    do_reset(2'b00);
    filt_a_high = 0;
    enc_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (dut.r_filt[1]) filt_a_high++;
    end
    enc_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dut.r_filt[1]) filt_a_high++;
    end
    checks++;
    if (filt_a_high != 0) begin
      errors++;
      $display("FAIL glitch_short_filt_a: high for %0d cycles, expected 0", filt_a_high);
    end
    drive_pair(2'b10, D, 1);
    drive_pair(2'b00, 20, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL glitch_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL glitch_event[%0d]: got cycle %0d kind %0d, expected cycle %0d kind %0d",
                   i, obs_q[i] / 8, obs_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
        end
      end
    end
  endtask

  task automatic test_error();
    do_reset(2'b00);
    // Double change; limpar_erro is held on the very edge that raises erro.
    drive_pair(2'b11, LAT - 1, 1);
    limpar_erro = 1'b1;
    @(negedge clk);
    limpar_erro = 1'b0;
    checks++;
    if (erro_sticky !== model_sticky) begin
      errors++;
      $display("FAIL err_set_wins: sticky %b, expected %b", erro_sticky, model_sticky);
    end
    repeat (10) @(negedge clk);
    limpar_erro = 1'b1;
    @(negedge clk);
    limpar_erro = 1'b0;
    model_sticky = 1'b0;
    checks++;
    if (erro_sticky !== model_sticky) begin
      errors++;
      $display("FAIL err_clear: sticky %b, expected %b", erro_sticky, model_sticky);
    end
    drive_pair(2'b10, 12, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL err_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL err_event[%0d]: got cycle %0d kind %0d, expected cycle %0d kind %0d",
                   i, obs_q[i] / 8, obs_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2'b00);
    drive_pair(2'b11, 10, 1);
    checks++;
    if (erro_sticky !== model_sticky) begin
      errors++;
      $display("FAIL mid_sticky_before: sticky %b, expected %b", erro_sticky, model_sticky);
    end
    // Start a legal step, then cut it off while its debounce count is running.
    drive_pair(2'b10, 3, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({acrescer, decrecer, erro, erro_sticky} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async_reset: got %b, expected 0000", {acrescer, decrecer, erro, erro_sticky});
    end
    model_sticky = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    drive_pair(2'b00, 12, 1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL mid_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL mid_event[%0d]: got cycle %0d kind %0d, expected cycle %0d kind %0d",
                   i, obs_q[i] / 8, obs_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
        end
      end
    end
    checks++;
    if (erro_sticky !== model_sticky) begin
      errors++;
      $display("FAIL mid_sticky_after: sticky %b, expected %b", erro_sticky, model_sticky);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4];
    seq[0] = 2'b01;
    seq[1] = 2'b11;
    seq[2] = 2'b10;
    seq[3] = 2'b00;
    do_reset(2'b00);
    for (int k = 0; k < 8; k++) begin
      drive_pair(seq[k % 4], D, 1);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_event[%0d]: got cycle %0d kind %0d, expected cycle %0d kind %0d",
                   i, obs_q[i] / 8, obs_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset(2'b00);
    for (int k = 0; k < 40; k++) begin
      drive_pair(2'($urandom_range(0, 3)), int'($urandom_range(8, 16)), 1);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rnd_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rnd_event[%0d]: got cycle %0d kind %0d, expected cycle %0d kind %0d",
                   i, obs_q[i] / 8, obs_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
        end
      end
    end
    checks++;
    if (erro_sticky !== model_sticky) begin
      errors++;
      $display("FAIL rnd_sticky: sticky %b, expected %b", erro_sticky, model_sticky);
    end
    limpar_erro = 1'b1;
    @(negedge clk);
    limpar_erro = 1'b0;
    @(negedge clk);
    checks++;
    if (erro_sticky !== 1'b0) begin
      errors++;
      $display("FAIL rnd_clear: sticky %b, expected 0", erro_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_error();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
